// File: rtl/gmsk_burst_sequencer.sv
// rtl/gmsk_burst_sequencer.sv - GMSK burst timing: lead tail, data, trail tail, guard, with bit prefetch
// Generates sample/symbol strobes and the 3-bit curve-select history for a ROM-based GMSK modulator.
module gmsk_burst_sequencer #(
  parameter int CLOCKS_PER_SAMPLE  = 8,
  parameter int SAMPLES_PER_SYMBOL = 128,
  parameter int BURST_LEN          = 148,
  parameter int TAIL_SYMBOLS       = 3,
  parameter int GUARD_SYMBOLS      = 8,
  localparam int IDX_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             sample_strobe,
  output logic             symbol_strobe,
  output logic [IDX_W-1:0] sample_index,
  output logic [2:0]       bit_history,
  output logic             tx_enable,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int DIV_W   = $clog2(CLOCKS_PER_SAMPLE);
  localparam int MAX_TB  = (TAIL_SYMBOLS > BURST_LEN) ? TAIL_SYMBOLS : BURST_LEN;
  localparam int MAX_LIM = (MAX_TB > GUARD_SYMBOLS) ? MAX_TB : GUARD_SYMBOLS;
  localparam int CNT_W   = (MAX_LIM > 0) ? $clog2(MAX_LIM + 1) : 1;
  localparam int ACC_W   = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;

  typedef enum logic [2:0] {IDLE, LEAD, DATA, TRAIL, GUARD} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   sym_cnt;
  logic [CNT_W-1:0]   limit_m1;
  logic [ACC_W-1:0]   accepted;
  logic               pf_valid, pf_bit;
  logic               last_sample, state_end, take, consume;

  // Next non-empty state in the burst sequence; zero-length phases are skipped.
  function automatic state_t following(input state_t s);
    state_t r;
    r = IDLE;
    case (s)
      IDLE:    r = (TAIL_SYMBOLS > 0)  ? LEAD  :
                   (BURST_LEN > 0)     ? DATA  :
                   (GUARD_SYMBOLS > 0) ? GUARD : IDLE;
      LEAD:    r = (BURST_LEN > 0)     ? DATA  :
                   (TAIL_SYMBOLS > 0)  ? TRAIL :
                   (GUARD_SYMBOLS > 0) ? GUARD : IDLE;
      DATA:    r = (TAIL_SYMBOLS > 0)  ? TRAIL :
                   (GUARD_SYMBOLS > 0) ? GUARD : IDLE;
      TRAIL:   r = (GUARD_SYMBOLS > 0) ? GUARD : IDLE;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  always_comb begin
    limit_m1      = '0;
    state_nx      = state;
    sample_strobe = (state != IDLE) && (div == DIV_W'(CLOCKS_PER_SAMPLE - 1));
    symbol_strobe = sample_strobe && (sample_index == '0);
    last_sample   = sample_strobe && (sample_index == IDX_W'(SAMPLES_PER_SYMBOL - 1));
    case (state)
      LEAD, TRAIL: limit_m1 = CNT_W'(TAIL_SYMBOLS - 1);
      DATA:        limit_m1 = CNT_W'(BURST_LEN - 1);
      GUARD:       limit_m1 = CNT_W'(GUARD_SYMBOLS - 1);
      default:     limit_m1 = '0;
    endcase
    state_end = last_sample && (sym_cnt == limit_m1);
    bit_ready = ((state == LEAD) || (state == DATA)) && !pf_valid &&
                (accepted < ACC_W'(BURST_LEN));
    take      = bit_valid && bit_ready;
    consume   = symbol_strobe && (state == DATA);
    tx_enable = (state == LEAD) || (state == DATA) || (state == TRAIL);
    busy      = (state != IDLE);
    if (state == IDLE) begin
      if (start) state_nx = following(IDLE);
    end else if (state_end) begin
      state_nx = following(state);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div          <= '0;
      sample_index <= '0;
      sym_cnt      <= '0;
      bit_history  <= 3'b000;
      pf_valid     <= 1'b0;
      pf_bit       <= 1'b0;
      accepted     <= '0;
      underrun     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state != IDLE) && (state_nx == IDLE);
      if (state == IDLE) begin
        div          <= '0;
        sample_index <= '0;
        sym_cnt      <= '0;
        if (start) begin
          bit_history <= 3'b000;
          pf_valid    <= 1'b0;
          pf_bit      <= 1'b0;
          accepted    <= '0;
          underrun    <= 1'b0;
        end
      end else begin
        div <= sample_strobe ? '0 : div + DIV_W'(1);
        if (sample_strobe)
          sample_index <= (sample_index == IDX_W'(SAMPLES_PER_SYMBOL - 1)) ? '0
                          : sample_index + IDX_W'(1);
        if (last_sample)
          sym_cnt <= state_end ? '0 : sym_cnt + CNT_W'(1);
        // Outside DATA, and on a DATA underrun, a zero enters the history.
        if (symbol_strobe)
          bit_history <= {consume && pf_valid && pf_bit, bit_history[2:1]};
        if (consume && !pf_valid)
          underrun <= 1'b1;
        if (take) begin
          pf_valid <= 1'b1;
          pf_bit   <= bit_in;
          accepted <= accepted + ACC_W'(1);
        end else if (consume) begin
          pf_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// tb/tb_gmsk_burst_sequencer.sv - randomized self-checking bench for gmsk_burst_sequencer
// Expected behaviour comes from a cycle-offset model of the burst timeline and a one-entry prefetch.
module tb_gmsk_burst_sequencer;

  localparam int CPS   = 2;
  localparam int SPS   = 4;
  localparam int BL    = 4;
  localparam int TAIL  = 1;
  localparam int GUARD = 1;
  localparam int P     = CPS * SPS;
  localparam int END_K = (2 * TAIL + BL + GUARD) * P;
  localparam int TX_K  = (2 * TAIL + BL) * P;

  logic       clock = 1'b0;
  logic       reset, start, bit_in, bit_valid;
  logic       bit_ready, sample_strobe, symbol_strobe;
  logic [1:0] sample_index;
  logic [2:0] bit_history;
  logic       tx_enable, busy, done, underrun;

  gmsk_burst_sequencer #(
    .CLOCKS_PER_SAMPLE (CPS),
    .SAMPLES_PER_SYMBOL(SPS),
    .BURST_LEN         (BL),
    .TAIL_SYMBOLS      (TAIL),
    .GUARD_SYMBOLS     (GUARD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_strobe(sample_strobe),
    .symbol_strobe(symbol_strobe),
    .sample_index (sample_index),
    .bit_history  (bit_history),
    .tx_enable    (tx_enable),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  bit         m_under, m_pf_full, m_pf_bit;
  int         m_acc;
  logic [2:0] m_hist;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " sample_strobe"}, 32'(sample_strobe), 0);
    check({tag, " symbol_strobe"}, 32'(symbol_strobe), 0);
    check({tag, " bit_ready"}, 32'(bit_ready), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " tx_enable"}, 32'(tx_enable), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " underrun"}, 32'(underrun), 32'(m_under));
    check({tag, " bit_history"}, 32'(bit_history), 32'(m_hist));
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      @(negedge clock);
      check_quiet("idle");
      @(posedge clock);
      #1;
    end
  endtask

  // mode: 0 always valid, 1 never valid, 2 valid on odd cycles, 3 random valid and stray starts
  task automatic run_burst(input int mode, input bit directed, input bit restart, input int reset_at);
    logic [BL-1:0] data_bits;
    logic [2:0]    hist_q[$];
    logic [2:0]    hist_exp[7];
    int            taken, sym_no;
    bit            prev_sym, abort, in_burst, in_data, exp_strobe, exp_sym, exp_ready, newb;
    string         t;
    hist_exp  = '{3'b000, 3'b100, 3'b010, 3'b101, 3'b110, 3'b011, 3'b001};
    data_bits = directed ? BL'(4'b1101) : BL'($urandom);
    taken     = 0;
    prev_sym  = 1'b0;
    abort     = 1'b0;
    for (int k = 0; k <= END_K + 1; k++) begin
      start = (k == 0) || (restart && k == 20) ||
              (mode == 3 && k >= 1 && k <= END_K && $urandom_range(0, 7) == 0);
      case (mode)
        0:       bit_valid = 1'b1;
        1:       bit_valid = 1'b0;
        2:       bit_valid = (k % 2 == 1);
        default: bit_valid = 1'($urandom);
      endcase
      bit_in = (m_acc < BL) ? data_bits[m_acc] : 1'($urandom);
      reset  = (k == reset_at);
      @(negedge clock);
      t = $sformatf("k%0d", k);
      if (reset) begin
        check({t, " rst sample_strobe"}, 32'(sample_strobe), 0);
        check({t, " rst symbol_strobe"}, 32'(symbol_strobe), 0);
        check({t, " rst bit_ready"}, 32'(bit_ready), 0);
        check({t, " rst tx_enable"}, 32'(tx_enable), 0);
        check({t, " rst busy"}, 32'(busy), 0);
        check({t, " rst done"}, 32'(done), 0);
        check({t, " rst underrun"}, 32'(underrun), 0);
        check({t, " rst sample_index"}, 32'(sample_index), 0);
        check({t, " rst bit_history"}, 32'(bit_history), 0);
        abort = 1'b1;
        break;
      end
      if (prev_sym) hist_q.push_back(bit_history);
      in_burst   = (k >= 1) && (k <= END_K);
      sym_no     = (k - 1) / P;
      in_data    = in_burst && sym_no >= TAIL && sym_no < TAIL + BL;
      exp_strobe = in_burst && (k % CPS == 0);
      exp_sym    = exp_strobe && ((k - CPS) % P == 0);
      exp_ready  = in_burst && sym_no < TAIL + BL && !m_pf_full && m_acc < BL;
      check({t, " sample_strobe"}, 32'(sample_strobe), 32'(exp_strobe));
      check({t, " symbol_strobe"}, 32'(symbol_strobe), 32'(exp_sym));
      check({t, " bit_ready"}, 32'(bit_ready), 32'(exp_ready));
      check({t, " tx_enable"}, 32'(tx_enable), 32'(in_burst && k <= TX_K));
      check({t, " busy"}, 32'(busy), 32'(in_burst));
      check({t, " done"}, 32'(done), 32'(k == END_K + 1));
      check({t, " underrun"}, 32'(underrun), 32'(m_under));
      check({t, " bit_history"}, 32'(bit_history), 32'(m_hist));
      if (in_burst) check({t, " sample_index"}, 32'(sample_index), 32'(((k - 1) / CPS) % SPS));
      if (bit_ready && bit_valid) taken++;
      prev_sym = symbol_strobe;
      if (exp_sym) begin
        newb = 1'b0;
        if (in_data) begin
          if (m_pf_full) newb = m_pf_bit;
          else           m_under = 1'b1;
          m_pf_full = 1'b0;
        end
        m_hist = {newb, m_hist[2:1]};
      end
      if (exp_ready && bit_valid) begin
        m_pf_full = 1'b1;
        m_pf_bit  = bit_in;
        m_acc++;
      end
      if (k == 0) begin
        m_under   = 1'b0;
        m_pf_full = 1'b0;
        m_acc     = 0;
        m_hist    = 3'b000;
      end
      @(posedge clock);
      #1;
    end
    if (abort) begin
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst hold busy", 32'(busy), 0);
        check("rst hold done", 32'(done), 0);
      end
      @(posedge clock);
      #1;
      reset     = 1'b0;
      m_under   = 1'b0;
      m_hist    = 3'b000;
      m_pf_full = 1'b0;
    end else begin
      check("bits accepted", 32'(taken), 32'(m_acc));
      if (directed) begin
        check("history count", 32'(hist_q.size()), 7);
        for (int i = 0; i < 7 && i < hist_q.size(); i++)
          check($sformatf("history %0d", i), 32'(hist_q[i]), 32'(hist_exp[i]));
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    m_under   = 1'b0;
    m_pf_full = 1'b0;
    m_pf_bit  = 1'b0;
    m_acc     = 0;
    m_hist    = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check_quiet("reset");
    check("reset sample_index", 32'(sample_index), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_gap(3);
    run_burst(0, 1'b1, 1'b0, -1);
    idle_gap(3);
    run_burst(1, 1'b0, 1'b0, -1);
    idle_gap(3);
    run_burst(0, 1'b1, 1'b1, -1);
    idle_gap(3);
    run_burst(2, 1'b0, 1'b0, -1);
    idle_gap(3);
    run_burst(3, 1'b0, 1'b0, 30);
    idle_gap(4);
    run_burst(0, 1'b0, 1'b0, -1);
    idle_gap(3);
    for (int r = 0; r < 6; r++) begin
      run_burst(3, 1'b0, 1'b0, -1);
      idle_gap(2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
